// File: rtl/demux_3bit_1to5_reg_pkg.sv
// demux_pkg: shared constants and helpers for the registered 3-bit 1-to-5 demux.
// Lane count, lane width, round-robin pointer limit and the all-lanes-valid mask.
package demux_pkg;

  localparam int          NUM_LANES = 5;
  localparam int          LANE_W    = 3;
  localparam logic [2:0]  PTR_MAX   = 3'd4;
  localparam logic [4:0]  ALL_VALID = 5'b11111;

  // Round-robin successor: 0->1->2->3->4->0
  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p >= PTR_MAX) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/demux_3bit_1to5_reg_dest_decoder.sv
// dest_decoder: combinational 3-bit lane index to 5-bit one-hot lane enable.
// Indices 5..7 produce no enable and raise the invalid flag.
module dest_decoder
  import demux_pkg::*;
(
  input  logic [2:0]           idx,
  output logic [NUM_LANES-1:0] en,
  output logic                 invalid
);

  // Decode index to one-hot enable; flag out-of-range indices
  always_comb begin
    en      = '0;
    invalid = 1'b0;
    case (idx)
      3'd0:    en = 5'b00001;
      3'd1:    en = 5'b00010;
      3'd2:    en = 5'b00100;
      3'd3:    en = 5'b01000;
      3'd4:    en = 5'b10000;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/demux_3bit_1to5_reg.sv
// demux_3bit_1to5_reg: registered 1-to-5 demultiplexer for 3-bit data.
// A write loads one of five held lane registers and sets its valid flag;
// DONE pulses when all five lanes become valid, ERR pulses on a bad select.
// Optional round-robin destination mode is compiled in with DEMUX_AUTO_EN.
module demux_3bit_1to5_reg
  import demux_pkg::*;
#(
  parameter int W = LANE_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [W-1:0]         I,
  input  logic [2:0]           S,
  input  logic                 WE,
  input  logic                 CLR,
`ifdef DEMUX_AUTO_EN
  input  logic                 AUTO,
`endif
  output logic [W-1:0]         O0,
  output logic [W-1:0]         O1,
  output logic [W-1:0]         O2,
  output logic [W-1:0]         O3,
  output logic [W-1:0]         O4,
  output logic [NUM_LANES-1:0] V,
  output logic                 DONE,
  output logic                 ERR
);

  logic [2:0]           dest;
  logic [NUM_LANES-1:0] lane_en;
  logic                 dest_bad;
  logic [NUM_LANES-1:0] wr_en;
  logic [NUM_LANES-1:0] v_next;
  logic [W-1:0]         lane [NUM_LANES];

`ifdef DEMUX_AUTO_EN
  logic [2:0]           ptr;

  // Destination comes from the round-robin pointer in AUTO, else from S
  always_comb begin
    dest = AUTO ? ptr : S;
  end

  // Pointer advances only on AUTO writes; CLR without such a write rewinds it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      ptr <= 3'd0;
    else if (WE && AUTO)
      ptr <= next_ptr(ptr);
    else if (CLR)
      ptr <= 3'd0;
  end
`else
  // Destination is always the manual select
  always_comb begin
    dest = S;
  end
`endif

  dest_decoder u_dest_decoder (
    .idx     (dest),
    .en      (lane_en),
    .invalid (dest_bad)
  );

  assign wr_en = {NUM_LANES{WE}} & lane_en;

  // Next valid mask: CLR leaves only the lane written this cycle (if any)
  always_comb begin
    v_next = V | wr_en;
    if (CLR)
      v_next = wr_en;
  end

  // --- write stage: lane registers load on their enable, others hold ---
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NUM_LANES; k++)
        lane[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++)
        if (wr_en[k])
          lane[k] <= I;
    end
  end

  // Valid flags plus registered DONE (rising into all-valid) and ERR pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      V    <= '0;
      DONE <= 1'b0;
      ERR  <= 1'b0;
    end else begin
      V    <= v_next;
      DONE <= (v_next == ALL_VALID) && (V != ALL_VALID) && !CLR;
      ERR  <= WE && dest_bad;
    end
  end

  assign O0 = lane[0];
  assign O1 = lane[1];
  assign O2 = lane[2];
  assign O3 = lane[3];
  assign O4 = lane[4];

endmodule

// File: tb/tb_demux_3bit_1to5_reg.sv
// tb_demux_3bit_1to5_reg: directed self-checking bench for demux_3bit_1to5_reg.
// Manual-mode scenarios always run; AUTO scenarios run when DEMUX_AUTO_EN is defined.
module tb_demux_3bit_1to5_reg;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] I   = 3'd0;
  logic [2:0] S   = 3'd0;
  logic       WE  = 1'b0;
  logic       CLR = 1'b0;
`ifdef DEMUX_AUTO_EN
  logic       AUTO = 1'b0;
`endif
  logic [2:0] O0, O1, O2, O3, O4;
  logic [4:0] V;
  logic       DONE, ERR;

  int checks   = 0;
  int failures = 0;

  demux_3bit_1to5_reg dut (
    .CLK  (CLK),
    .RST  (RST),
    .I    (I),
    .S    (S),
    .WE   (WE),
    .CLR  (CLR),
`ifdef DEMUX_AUTO_EN
    .AUTO (AUTO),
`endif
    .O0   (O0),
    .O1   (O1),
    .O2   (O2),
    .O3   (O3),
    .O4   (O4),
    .V    (V),
    .DONE (DONE),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                           input logic [2:0] e2, input logic [2:0] e3, input logic [2:0] e4);
    chk({tag, "_O0"}, {5'd0, O0}, {5'd0, e0});
    chk({tag, "_O1"}, {5'd0, O1}, {5'd0, e1});
    chk({tag, "_O2"}, {5'd0, O2}, {5'd0, e2});
    chk({tag, "_O3"}, {5'd0, O3}, {5'd0, e3});
    chk({tag, "_O4"}, {5'd0, O4}, {5'd0, e4});
  endtask

  task automatic chk_flags(input string tag, input logic [4:0] ev, input logic ed, input logic ee);
    chk({tag, "_V"},    {3'd0, V},    {3'd0, ev});
    chk({tag, "_DONE"}, {7'd0, DONE}, {7'd0, ed});
    chk({tag, "_ERR"},  {7'd0, ERR},  {7'd0, ee});
  endtask

  // One write cycle; outputs are sampled 1 time unit after the edge
  task automatic wr(input logic [2:0] sel, input logic [2:0] dat, input logic clr);
    S   = sel;
    I   = dat;
    WE  = 1'b1;
    CLR = clr;
    @(posedge CLK); #1;
    WE  = 1'b0;
    CLR = 1'b0;
  endtask

  task automatic idle();
    @(posedge CLK); #1;
  endtask

  task automatic clear_only();
    CLR = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0;
  endtask

  // Assert reset between edges and check it acts without a clock edge
  task automatic async_reset(input string tag);
    #2 RST = 1'b1;
    #1;
    chk_lanes(tag, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk_flags(tag, 5'b00000, 1'b0, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk_lanes("rst", 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk_flags("rst", 5'b00000, 1'b0, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle();

    // Scenario 1: manual writes fill all lanes, DONE after the last one
    wr(3'd0, 3'd1, 1'b0); chk_flags("m_w0", 5'b00001, 1'b0, 1'b0);
    wr(3'd1, 3'd2, 1'b0); chk_flags("m_w1", 5'b00011, 1'b0, 1'b0);
    wr(3'd2, 3'd3, 1'b0); chk_flags("m_w2", 5'b00111, 1'b0, 1'b0);
    wr(3'd3, 3'd4, 1'b0); chk_flags("m_w3", 5'b01111, 1'b0, 1'b0);
    wr(3'd4, 3'd5, 1'b0); chk_flags("m_w4", 5'b11111, 1'b1, 1'b0);
    chk_lanes("m_fill", 3'd1, 3'd2, 3'd3, 3'd4, 3'd5);
    idle();               chk_flags("m_hold", 5'b11111, 1'b0, 1'b0);

    // Scenario 2: out-of-range select raises ERR only
    wr(3'd6, 3'd7, 1'b0); chk_flags("m_bad", 5'b11111, 1'b0, 1'b1);
    chk_lanes("m_bad", 3'd1, 3'd2, 3'd3, 3'd4, 3'd5);
    idle();               chk_flags("m_bad_end", 5'b11111, 1'b0, 1'b0);

    // Overwrite of a valid lane; full mask held does not retrigger DONE
    wr(3'd2, 3'd7, 1'b0); chk_flags("m_ovw", 5'b11111, 1'b0, 1'b0);
    chk_lanes("m_ovw", 3'd1, 3'd2, 3'd7, 3'd4, 3'd5);

    // CLR alone clears flags, data holds
    clear_only();         chk_flags("m_clr", 5'b00000, 1'b0, 1'b0);
    chk_lanes("m_clr", 3'd1, 3'd2, 3'd7, 3'd4, 3'd5);

    // CLR with a manual write leaves only that lane valid
    wr(3'd1, 3'd6, 1'b1); chk_flags("m_clrwe", 5'b00010, 1'b0, 1'b0);
    chk_lanes("m_clrwe", 3'd1, 3'd6, 3'd7, 3'd4, 3'd5);

    // Refill remaining lanes; DONE fires again on the completing write
    wr(3'd0, 3'd3, 1'b0);
    wr(3'd2, 3'd2, 1'b0);
    wr(3'd3, 3'd1, 1'b0); chk_flags("m_ref3", 5'b01111, 1'b0, 1'b0);
    wr(3'd4, 3'd0, 1'b0); chk_flags("m_ref4", 5'b11111, 1'b1, 1'b0);
    chk_lanes("m_ref", 3'd3, 3'd6, 3'd2, 3'd1, 3'd0);

    // Scenario 5 (manual): reset mid-sequence, next write lands where selected
    wr(3'd3, 3'd2, 1'b0);
    async_reset("m_arst");
    wr(3'd0, 3'd5, 1'b0); chk_flags("m_after_rst", 5'b00001, 1'b0, 1'b0);
    chk_lanes("m_after_rst", 3'd5, 3'd0, 3'd0, 3'd0, 3'd0);

`ifdef DEMUX_AUTO_EN
    // Scenario 3: seven AUTO writes wrap the pointer
    async_reset("a_rst");
    AUTO = 1'b1;
    wr(3'd7, 3'd1, 1'b0); chk_flags("a_w1", 5'b00001, 1'b0, 1'b0);
    wr(3'd7, 3'd2, 1'b0); chk_flags("a_w2", 5'b00011, 1'b0, 1'b0);
    wr(3'd7, 3'd3, 1'b0); chk_flags("a_w3", 5'b00111, 1'b0, 1'b0);
    wr(3'd7, 3'd4, 1'b0); chk_flags("a_w4", 5'b01111, 1'b0, 1'b0);
    wr(3'd7, 3'd5, 1'b0); chk_flags("a_w5", 5'b11111, 1'b1, 1'b0);
    wr(3'd7, 3'd6, 1'b0); chk_flags("a_w6", 5'b11111, 1'b0, 1'b0);
    wr(3'd7, 3'd7, 1'b0); chk_flags("a_w7", 5'b11111, 1'b0, 1'b0);
    chk_lanes("a_seq", 3'd6, 3'd7, 3'd3, 3'd4, 3'd5);

    // Pointer now 2: next AUTO write lands in lane 2
    wr(3'd7, 3'd0, 1'b0);
    chk_lanes("a_ptr2", 3'd6, 3'd7, 3'd0, 3'd4, 3'd5);

    // Scenario 4: CLR with AUTO write at pointer 3
    wr(3'd7, 3'd5, 1'b1); chk_flags("a_clrwe", 5'b01000, 1'b0, 1'b0);
    chk_lanes("a_clrwe", 3'd6, 3'd7, 3'd0, 3'd5, 3'd5);
    // Pointer advanced to 4
    wr(3'd7, 3'd1, 1'b0); chk_flags("a_ptr4", 5'b11000, 1'b0, 1'b0);
    chk_lanes("a_ptr4", 3'd6, 3'd7, 3'd0, 3'd5, 3'd1);

    // Manual write does not move the pointer (wrapped to 0)
    AUTO = 1'b0;
    wr(3'd2, 3'd3, 1'b0);
    AUTO = 1'b1;
    wr(3'd7, 3'd2, 1'b0); chk_flags("a_toggle", 5'b11101, 1'b0, 1'b0);
    chk_lanes("a_toggle", 3'd2, 3'd7, 3'd3, 3'd5, 3'd1);

    // Scenario 5 (AUTO): reset after three writes, next write goes to lane 0
    async_reset("a_rst2");
    wr(3'd7, 3'd1, 1'b0);
    wr(3'd7, 3'd2, 1'b0);
    wr(3'd7, 3'd3, 1'b0);
    async_reset("a_arst");
    wr(3'd7, 3'd4, 1'b0); chk_flags("a_after_rst", 5'b00001, 1'b0, 1'b0);
    chk_lanes("a_after_rst", 3'd4, 3'd0, 3'd0, 3'd0, 3'd0);
    AUTO = 1'b0;
`endif

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
